// File: rtl/load_issue_scheduler.sv
// Load issue scheduler: selects the oldest eligible LDQ load via an age matrix and drives the D-cache read port.
// Optional feature macro: LIS_REPLAY_EN (adds replay ports and per-entry replay back-off counters).
module load_issue_scheduler #(
  parameter int LDQ_ENTRIES  = 8,
  parameter int ADDR_W       = 32,
  parameter int REPLAY_DELAY = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alloc_valid,
  input  logic [$clog2(LDQ_ENTRIES)-1:0]  alloc_idx,
  input  logic                            dealloc_valid,
  input  logic [$clog2(LDQ_ENTRIES)-1:0]  dealloc_idx,
  input  logic [LDQ_ENTRIES-1:0]          ldq_valid,
  input  logic [LDQ_ENTRIES-1:0]          ldq_addr_valid,
  input  logic [LDQ_ENTRIES-1:0]          ldq_issued,
  input  logic [LDQ_ENTRIES-1:0]          ldq_st_clear,
  input  logic [LDQ_ENTRIES*ADDR_W-1:0]   ldq_addr,
  input  logic                            flush,
`ifdef LIS_REPLAY_EN
  input  logic                            replay_valid,
  input  logic [$clog2(LDQ_ENTRIES)-1:0]  replay_idx,
`endif
  output logic                            issue_mark_valid,
  output logic [$clog2(LDQ_ENTRIES)-1:0]  issue_mark_idx,
  output logic                            dc_req_valid,
  input  logic                            dc_req_ready,
  output logic [ADDR_W-1:0]               dc_req_addr,
  output logic [$clog2(LDQ_ENTRIES)-1:0]  dc_req_tag,
  output logic                            busy
);

  localparam int IDX_W = $clog2(LDQ_ENTRIES);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                                  r_state, w_next;
  logic [LDQ_ENTRIES-1:0][LDQ_ENTRIES-1:0] r_age;
  logic [IDX_W-1:0]                        r_tag;
  logic [ADDR_W-1:0]                       r_addr;
  logic                                    r_mark;
  logic [LDQ_ENTRIES-1:0]                  w_elig;
  logic [LDQ_ENTRIES-1:0]                  w_win;
  logic [LDQ_ENTRIES-1:0]                  w_replay_ok;
  logic                                    w_any;
  logic                                    w_load;
  logic [IDX_W-1:0]                        w_sel;
  logic [ADDR_W-1:0]                       w_sel_addr;

`ifdef LIS_REPLAY_EN
  localparam int CNT_W = $clog2(REPLAY_DELAY + 1);
  logic [LDQ_ENTRIES-1:0][CNT_W-1:0] r_replay_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_replay_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < LDQ_ENTRIES; i++) begin
        if (replay_valid && replay_idx == IDX_W'(i))
          r_replay_cnt[i] <= CNT_W'(REPLAY_DELAY);
        else if (r_replay_cnt[i] != '0)
          r_replay_cnt[i] <= r_replay_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    w_replay_ok = '0;
    for (int unsigned i = 0; i < LDQ_ENTRIES; i++)
      w_replay_ok[i] = (r_replay_cnt[i] == '0);
  end
`else
  assign w_replay_ok = '1;
`endif

  // Alloc is checked before dealloc so a same-index alloc/dealloc pair leaves the alloc's column in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_age <= '0;
    end else begin
      for (int unsigned i = 0; i < LDQ_ENTRIES; i++) begin
        for (int unsigned j = 0; j < LDQ_ENTRIES; j++) begin
          if (alloc_valid && alloc_idx == IDX_W'(i))
            r_age[i][j] <= 1'b0;
          else if (alloc_valid && alloc_idx == IDX_W'(j))
            r_age[i][j] <= ldq_valid[i];
          else if (dealloc_valid && (dealloc_idx == IDX_W'(i) || dealloc_idx == IDX_W'(j)))
            r_age[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < LDQ_ENTRIES; i++)
      w_elig[i] = ldq_valid[i] & ldq_addr_valid[i] & ~ldq_issued[i] & ldq_st_clear[i]
                & ~((r_state == S_REQ) && (r_tag == IDX_W'(i))) & w_replay_ok[i];
  end

  // An entry wins when no other eligible entry is older than it.
  always_comb begin
    w_win = '0;
    for (int unsigned i = 0; i < LDQ_ENTRIES; i++) begin
      w_win[i] = w_elig[i];
      for (int unsigned j = 0; j < LDQ_ENTRIES; j++)
        if (w_elig[j] && r_age[j][i]) w_win[i] = 1'b0;
    end
  end

  always_comb begin
    w_sel      = '0;
    w_sel_addr = '0;
    for (int unsigned i = LDQ_ENTRIES; i > 0; i--) begin
      if (w_win[i-1]) begin
        w_sel      = IDX_W'(i-1);
        w_sel_addr = ldq_addr[(i-1)*ADDR_W +: ADDR_W];
      end
    end
    w_any = |w_win;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tag   <= '0;
      r_addr  <= '0;
      r_mark  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mark  <= w_load;
      if (w_load) begin
        r_tag  <= w_sel;
        r_addr <= w_sel_addr;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            w_next = S_REQ;
            w_load = 1'b1;
          end
        end
        S_REQ: begin
          if (dc_req_ready) begin
            w_load = w_any;
            if (w_any) w_next = S_REQ;
            else       w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy             = (r_state == S_REQ);
    dc_req_valid     = (r_state == S_REQ);
    dc_req_addr      = (r_state == S_REQ) ? r_addr : '0;
    dc_req_tag       = (r_state == S_REQ) ? r_tag : '0;
    issue_mark_valid = r_mark;
    issue_mark_idx   = r_mark ? r_tag : '0;
  end

endmodule

// File: tb/tb_load_issue_scheduler.sv
// Directed bench for load_issue_scheduler: table of selection vectors plus hand-written multi-cycle sequences.
module tb_load_issue_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         alloc_valid, dealloc_valid, flush, dc_req_ready;
  logic [2:0]   alloc_idx, dealloc_idx;
  logic [7:0]   ldq_valid, ldq_addr_valid, ldq_issued, ldq_st_clear;
  logic [255:0] ldq_addr;
  logic         issue_mark_valid, dc_req_valid, busy;
  logic [2:0]   issue_mark_idx, dc_req_tag;
  logic [31:0]  dc_req_addr;
`ifdef LIS_REPLAY_EN
  logic         replay_valid = 1'b0;
  logic [2:0]   replay_idx = 3'd0;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int n_marks;

  typedef struct {
    logic [7:0]  v, av, iss, sc;
    logic        exp_valid;
    logic [2:0]  exp_tag;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vt[8];
  int   order[8];

  load_issue_scheduler #(.LDQ_ENTRIES(8), .ADDR_W(32), .REPLAY_DELAY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .dealloc_valid(dealloc_valid), .dealloc_idx(dealloc_idx),
    .ldq_valid(ldq_valid), .ldq_addr_valid(ldq_addr_valid),
    .ldq_issued(ldq_issued), .ldq_st_clear(ldq_st_clear),
    .ldq_addr(ldq_addr), .flush(flush),
`ifdef LIS_REPLAY_EN
    .replay_valid(replay_valid), .replay_idx(replay_idx),
`endif
    .issue_mark_valid(issue_mark_valid), .issue_mark_idx(issue_mark_idx),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && dealloc_valid && busy)
      assert (dealloc_idx != dc_req_tag) else $error("illegal dealloc of pending tag %0d", dealloc_idx);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; acts as the LDQ setting issued for an entry marked in the cycle just ended.
  task automatic tick();
    logic       m;
    logic [2:0] mi;
    m  = issue_mark_valid;
    mi = issue_mark_idx;
    @(posedge clk);
    #1;
    if (m) ldq_issued[mi] = 1'b1;
    if (issue_mark_valid) n_marks++;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    alloc_valid = 1'b0; alloc_idx = '0; dealloc_valid = 1'b0; dealloc_idx = '0;
    flush = 1'b0; dc_req_ready = 1'b0;
    ldq_valid = '0; ldq_addr_valid = '0; ldq_issued = '0; ldq_st_clear = '0; ldq_addr = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic do_alloc(input int k);
    alloc_valid = 1'b1;
    alloc_idx   = 3'(k);
    tick();
    alloc_valid  = 1'b0;
    ldq_valid[k] = 1'b1;
  endtask

  task automatic set_entry(input int k, input logic av, input logic sc, input logic [31:0] a);
    ldq_addr_valid[k]    = av;
    ldq_st_clear[k]      = sc;
    ldq_addr[k*32 +: 32] = a;
  endtask

  task automatic chk_req(input string name, input logic [2:0] tag, input logic [31:0] addr, input logic mark);
    chk({name, "_valid"}, 32'(dc_req_valid), 32'd1);
    chk({name, "_tag"}, 32'(dc_req_tag), 32'(tag));
    chk({name, "_addr"}, dc_req_addr, addr);
    chk({name, "_mark"}, {31'd0, issue_mark_valid}, {31'd0, mark});
    if (mark) chk({name, "_markidx"}, 32'(issue_mark_idx), 32'(tag));
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_idle"}, {28'd0, dc_req_valid, issue_mark_valid, busy, 1'b0}, 32'd0);
  endtask

  initial begin
    vt[0] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1, 3'd5, 32'h8000_0050};
    vt[1] = '{8'hFF, 8'hDF, 8'h00, 8'hFF, 1'b1, 3'd2, 32'h8000_0020};
    vt[2] = '{8'hFF, 8'hFF, 8'h24, 8'hFF, 1'b1, 3'd7, 32'h8000_0070};
    vt[3] = '{8'hFF, 8'hFF, 8'h00, 8'h5A, 1'b1, 3'd3, 32'h8000_0030};
    vt[4] = '{8'hFF, 8'h10, 8'h00, 8'hFF, 1'b1, 3'd4, 32'h8000_0040};
    vt[5] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, 3'd0, 32'h0000_0000};
    vt[6] = '{8'hFF, 8'h12, 8'h00, 8'hFF, 1'b1, 3'd1, 32'h8000_0010};
    vt[7] = '{8'hDB, 8'hFF, 8'h00, 8'hFF, 1'b1, 3'd7, 32'h8000_0070};
    order = '{5, 2, 7, 0, 3, 6, 1, 4};
    n_marks = 0;

    // T1: reset held with an eligible entry present
    reset_dut();
    ldq_valid[0] = 1'b1;
    set_entry(0, 1'b1, 1'b1, 32'h0000_00A0);
    rst_n = 1'b0;
    tick();
    chk_idle("t1_rst_c1");
    chk("t1_rst_c1_addr", dc_req_addr, 32'd0);
    tick();
    chk_idle("t1_rst_c2");
    chk("t1_rst_c2_tag", {29'd0, dc_req_tag}, 32'd0);
    rst_n = 1'b1;
    chk_idle("t1_release");
    tick();
    chk_req("t1_first", 3'd0, 32'h0000_00A0, 1'b1);

    // Selection table over a fixed allocation order (oldest first: 5,2,7,0,3,6,1,4)
    reset_dut();
    for (int i = 0; i < 8; i++) ldq_addr[i*32 +: 32] = 32'h8000_0000 + 32'(i * 16);
    for (int k = 0; k < 8; k++) do_alloc(order[k]);
    for (int n = 0; n < 8; n++) begin
      ldq_valid = vt[n].v; ldq_addr_valid = vt[n].av;
      ldq_issued = vt[n].iss; ldq_st_clear = vt[n].sc;
      tick();
      if (vt[n].exp_valid) chk_req($sformatf("tab%0d", n), vt[n].exp_tag, vt[n].exp_addr, 1'b1);
      else                 chk_idle($sformatf("tab%0d", n));
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end

    // T2: age order 3,1,5 issued back-to-back
    reset_dut();
    set_entry(3, 1'b0, 1'b1, 32'h0000_0300);
    set_entry(1, 1'b0, 1'b1, 32'h0000_0100);
    set_entry(5, 1'b0, 1'b1, 32'h0000_0500);
    do_alloc(3); do_alloc(1); do_alloc(5);
    dc_req_ready = 1'b1;
    ldq_addr_valid = 8'b0010_1010;
    tick(); chk_req("t2_a", 3'd3, 32'h0000_0300, 1'b1);
    tick(); chk_req("t2_b", 3'd1, 32'h0000_0100, 1'b1);
    tick(); chk_req("t2_c", 3'd5, 32'h0000_0500, 1'b1);
    tick(); chk_idle("t2_end");

    // T3: backpressure holds the request with a single mark pulse
    reset_dut();
    ldq_valid[2] = 1'b1;
    set_entry(2, 1'b1, 1'b1, 32'h0000_1000);
    n_marks = 0;
    tick(); chk_req("t3_first", 3'd2, 32'h0000_1000, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick(); chk_req($sformatf("t3_hold%0d", c), 3'd2, 32'h0000_1000, 1'b0);
    end
    dc_req_ready = 1'b1;
    tick(); chk_idle("t3_done");
    chk("t3_mark_count", 32'(n_marks), 32'd1);

    // T4: older load blocked by stores, younger load goes first
    reset_dut();
    set_entry(0, 1'b1, 1'b0, 32'h0000_4000);
    do_alloc(0);
    do_alloc(4);
    set_entry(4, 1'b1, 1'b1, 32'h0000_4400);
    dc_req_ready = 1'b1;
    tick(); chk_req("t4_young", 3'd4, 32'h0000_4400, 1'b1);
    tick(); chk_idle("t4_blocked1");
    tick(); chk_idle("t4_blocked2");
    ldq_st_clear[0] = 1'b1;
    tick(); chk_req("t4_old", 3'd0, 32'h0000_4000, 1'b1);
    tick(); chk_idle("t4_end");

    // Same-cycle alloc and dealloc of one index: the alloc's age ordering survives
    reset_dut();
    set_entry(6, 1'b0, 1'b1, 32'h0000_6000);
    set_entry(2, 1'b0, 1'b1, 32'h0000_2000);
    do_alloc(6);
    alloc_valid = 1'b1; alloc_idx = 3'd2; dealloc_valid = 1'b1; dealloc_idx = 3'd2;
    tick();
    alloc_valid = 1'b0; dealloc_valid = 1'b0; ldq_valid[2] = 1'b1;
    ldq_addr_valid = 8'b0100_0100;
    dc_req_ready = 1'b1;
    tick(); chk_req("aw_first", 3'd6, 32'h0000_6000, 1'b1);
    tick(); chk_req("aw_second", 3'd2, 32'h0000_2000, 1'b1);

    // T5: flush beats a same-cycle handshake
    reset_dut();
    set_entry(6, 1'b0, 1'b1, 32'h0000_0600);
    set_entry(7, 1'b0, 1'b1, 32'h0000_0700);
    do_alloc(6); do_alloc(7);
    ldq_addr_valid = 8'b1100_0000;
    dc_req_ready = 1'b1;
    tick(); chk_req("t5_req", 3'd6, 32'h0000_0600, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_idle("t5_flushed");
    chk("t5_addr", dc_req_addr, 32'd0);
    tick(); chk_req("t5_next", 3'd7, 32'h0000_0700, 1'b1);

`ifdef LIS_REPLAY_EN
    // T6: replayed entry re-requests five edges after the replay is sampled
    reset_dut();
    ldq_valid[6] = 1'b1;
    set_entry(6, 1'b1, 1'b1, 32'h0000_6600);
    dc_req_ready = 1'b1;
    tick(); chk_req("t6_req", 3'd6, 32'h0000_6600, 1'b1);
    tick(); chk_idle("t6_done");
    replay_valid = 1'b1; replay_idx = 3'd6;
    tick();
    replay_valid = 1'b0; ldq_issued[6] = 1'b0;
    for (int c = 1; c < 5; c++) begin
      tick(); chk_idle($sformatf("t6_wait%0d", c));
    end
    tick(); chk_req("t6_rereq", 3'd6, 32'h0000_6600, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
